// File: rtl/buzz_pattern.sv
// Programmable beeper: plays N beeps of a square-wave tone, each with an on time
// and an off time counted in prescaled ticks, behind a start/stop/busy/done handshake.
module buzz_pattern #(
    parameter int TICK_DIV = 50000,
    parameter int DIV_W    = 16,
    parameter int DUR_W    = 10,
    parameter int CNT_W    = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             stop,
    input  logic [DIV_W-1:0] half_period,
    input  logic [DUR_W-1:0] on_ticks,
    input  logic [DUR_W-1:0] off_ticks,
    input  logic [CNT_W-1:0] beeps,
    output logic             busy,
    output logic             done,
    output logic             buz,
    output logic [1:0]       dbg_state
);

    localparam int PRE_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [PRE_W-1:0] PRE_MAX  = PRE_W'(TICK_DIV - 1);
    localparam logic [CNT_W-1:0] ONE_BEEP = CNT_W'(1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        TONE = 2'd1,
        GAP  = 2'd2
    } state_t;

    state_t           state, state_next;
    logic [DIV_W-1:0] hp_l;
    logic [DUR_W-1:0] on_l, off_l;
    logic [CNT_W-1:0] rem;
    logic [PRE_W-1:0] pre;
    logic [DUR_W-1:0] tick;
    logic [DIV_W-1:0] tone_cnt;
    logic [DUR_W-1:0] cur_len;
    logic             phase_end;
    logic             load_cfg, enter_phase, dec_rem, done_next;

    // The phase ends on the last clock of its final tick.
    assign cur_len   = (state == GAP) ? off_l : on_l;
    assign phase_end = (pre == PRE_MAX) && (tick == cur_len - DUR_W'(1));

    assign busy      = (state != IDLE);
    assign dbg_state = state;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= IDLE;
        else      state <= state_next;
    end

    always_comb begin
        state_next  = state;
        load_cfg    = 1'b0;
        enter_phase = 1'b0;
        dec_rem     = 1'b0;
        done_next   = 1'b0;
        case (state)
            IDLE: begin
                if (start && !stop) begin
                    if (beeps != '0 && on_ticks != '0) begin
                        load_cfg    = 1'b1;
                        enter_phase = 1'b1;
                        state_next  = TONE;
                    end else begin
                        done_next = 1'b1;
                    end
                end
            end
            TONE: begin
                if (stop) begin
                    state_next = IDLE;
                end else if (phase_end) begin
                    if (rem > ONE_BEEP) begin
                        enter_phase = 1'b1;
                        if (off_l != '0) begin
                            state_next = GAP;
                        end else begin
                            // No gap: the next beep restarts the tone immediately.
                            state_next = TONE;
                            dec_rem    = 1'b1;
                        end
                    end else begin
                        state_next = IDLE;
                        done_next  = 1'b1;
                    end
                end
            end
            GAP: begin
                if (stop) begin
                    state_next = IDLE;
                end else if (phase_end) begin
                    state_next  = TONE;
                    enter_phase = 1'b1;
                    dec_rem     = 1'b1;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            hp_l     <= '0;
            on_l     <= '0;
            off_l    <= '0;
            rem      <= '0;
            pre      <= '0;
            tick     <= '0;
            tone_cnt <= '0;
            buz      <= 1'b0;
            done     <= 1'b0;
        end else begin
            done <= done_next;

            if (load_cfg) begin
                hp_l  <= half_period;
                on_l  <= on_ticks;
                off_l <= off_ticks;
                rem   <= beeps;
            end else if (dec_rem) begin
                rem <= rem - ONE_BEEP;
            end

            if (enter_phase || state_next == IDLE) begin
                pre  <= '0;
                tick <= '0;
            end else if (pre == PRE_MAX) begin
                pre  <= '0;
                tick <= tick + DUR_W'(1);
            end else begin
                pre <= pre + PRE_W'(1);
            end

            // Tone generator restarts low on every TONE entry; silent when half-period is 0.
            if (enter_phase || state_next != TONE || hp_l == '0) begin
                tone_cnt <= '0;
                buz      <= 1'b0;
            end else if (tone_cnt == hp_l - DIV_W'(1)) begin
                tone_cnt <= '0;
                buz      <= ~buz;
            end else begin
                tone_cnt <= tone_cnt + DIV_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_buzz_pattern.sv
// Bench for buzz_pattern: output edges become timestamped events checked against
// a queue of hand-computed expected events.
module tb_buzz_pattern;

    localparam int TICK_DIV = 10;

    localparam int EV_BUSY_UP = 1;
    localparam int EV_BUSY_DN = 2;
    localparam int EV_DONE    = 3;
    localparam int EV_BUZ_UP  = 4;

    logic        clk;
    logic        rst;
    logic        start, stop;
    logic [15:0] half_period;
    logic [9:0]  on_ticks, off_ticks;
    logic [3:0]  beeps;
    logic        busy, done, buz;
    logic [1:0]  dbg_state;

    int checks = 0;
    int passes = 0;
    int cyc    = 0;
    int t0     = 0;

    logic [15:0] exp_q[$];

    buzz_pattern #(
        .TICK_DIV(TICK_DIV),
        .DIV_W   (16),
        .DUR_W   (10),
        .CNT_W   (4)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .stop       (stop),
        .half_period(half_period),
        .on_ticks   (on_ticks),
        .off_ticks  (off_ticks),
        .beeps      (beeps),
        .busy       (busy),
        .done       (done),
        .buz        (buz),
        .dbg_state  (dbg_state)
    );

    // clock / reset
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act == exp) passes++;
        else $display("FAIL %s: got %0d expected %0d", name, act, exp);
    endtask

    task automatic push_ev(input int kind, input int c);
        exp_q.push_back({4'(kind), 12'(c)});
    endtask

    // monitor: turns output changes into events at cycle offsets from the last start
    logic p_busy = 1'b0;
    logic p_buz  = 1'b0;

    task automatic got_ev(input int kind, input int c);
        logic [15:0] got, want;
        got = {4'(kind), 12'(c)};
        checks++;
        if (exp_q.size() == 0) begin
            $display("FAIL event: got kind=%0d cyc=%0d expected none", kind, c);
        end else begin
            want = exp_q.pop_front();
            if (got == want) passes++;
            else $display("FAIL event: got kind=%0d cyc=%0d expected kind=%0d cyc=%0d",
                          kind, c, want[15:12], want[11:0]);
        end
    endtask

    always @(negedge clk) begin
        int rel;
        rel = cyc - t0;
        if (busy && !p_busy) got_ev(EV_BUSY_UP, rel);
        if (!busy && p_busy) got_ev(EV_BUSY_DN, rel);
        if (done)            got_ev(EV_DONE, rel);
        if (buz && !p_buz)   got_ev(EV_BUZ_UP, rel);
        p_busy = busy;
        p_buz  = buz;
    end

    // driver tasks
    task automatic do_start(input int hp, input int on, input int off, input int b);
        @(posedge clk); #2;
        half_period = 16'(hp);
        on_ticks    = 10'(on);
        off_ticks   = 10'(off);
        beeps       = 4'(b);
        start       = 1'b1;
        t0          = cyc;
        @(posedge clk); #2;
        start = 1'b0;
    endtask

    task automatic wait_rel(input int n);
        while (cyc - t0 < n) begin
            @(posedge clk); #2;
        end
    endtask

    task automatic settle(input string name, input int n);
        repeat (n) @(posedge clk);
        #2;
        check(name, exp_q.size(), 0);
    endtask

    initial begin
        start = 1'b0; stop = 1'b0;
        half_period = '0; on_ticks = '0; off_ticks = '0; beeps = '0;
        rst = 1'b1;
        #1 rst = 1'b0;
        repeat (3) @(posedge clk);
        #2;
        check("reset_busy", int'(busy), 0);
        check("reset_done", int'(done), 0);
        check("reset_buz", int'(buz), 0);
        check("reset_state", int'(dbg_state), 0);
        rst = 1'b1;
        repeat (2) @(posedge clk);

        // single beep: 30 busy cycles, rises every 8 from cycle 5, done at 31
        push_ev(EV_BUSY_UP, 1);
        for (int i = 0; i < 4; i++) push_ev(EV_BUZ_UP, 5 + 8 * i);
        push_ev(EV_BUSY_DN, 31);
        push_ev(EV_DONE, 31);
        do_start(4, 3, 2, 1);
        settle("drain_single", 40);

        // three beeps with 20-cycle gaps, busy 130 cycles
        push_ev(EV_BUSY_UP, 1);
        for (int b = 0; b < 3; b++)
            for (int i = 0; i < 4; i++) push_ev(EV_BUZ_UP, 1 + 50 * b + 4 + 8 * i);
        push_ev(EV_BUSY_DN, 131);
        push_ev(EV_DONE, 131);
        do_start(4, 3, 2, 3);
        settle("drain_three", 140);

        // zero gap: tone restarts at 31, next rise at 35
        push_ev(EV_BUSY_UP, 1);
        for (int i = 0; i < 4; i++) push_ev(EV_BUZ_UP, 5 + 8 * i);
        for (int i = 0; i < 4; i++) push_ev(EV_BUZ_UP, 35 + 8 * i);
        push_ev(EV_BUSY_DN, 61);
        push_ev(EV_DONE, 61);
        do_start(4, 3, 0, 2);
        settle("drain_nogap", 70);

        // stop mid-burst; start while busy and start+stop are both ignored
        push_ev(EV_BUSY_UP, 1);
        push_ev(EV_BUZ_UP, 5);
        push_ev(EV_BUZ_UP, 13);
        push_ev(EV_BUSY_DN, 16);
        do_start(4, 3, 2, 1);
        wait_rel(8);
        half_period = 16'd1; on_ticks = 10'd1; beeps = 4'd5; start = 1'b1;
        wait_rel(9);
        start = 1'b0;
        wait_rel(15);
        stop = 1'b1;
        wait_rel(16);
        check("stop_busy", int'(busy), 0);
        check("stop_buz", int'(buz), 0);
        start = 1'b1;
        wait_rel(17);
        start = 1'b0; stop = 1'b0;
        check("start_stop_busy", int'(busy), 0);
        settle("drain_stop", 30);

        // degenerate requests: done one cycle after start, busy never raised
        push_ev(EV_DONE, 1);
        do_start(4, 3, 2, 0);
        settle("drain_zero_beeps", 10);
        push_ev(EV_DONE, 1);
        do_start(4, 0, 2, 2);
        settle("drain_zero_on", 10);

        // silent beep: no buz activity, normal busy timing
        push_ev(EV_BUSY_UP, 1);
        push_ev(EV_BUSY_DN, 21);
        push_ev(EV_DONE, 21);
        do_start(0, 2, 1, 1);
        settle("drain_silent", 30);

        // new start accepted in the done cycle
        push_ev(EV_BUSY_UP, 1);
        push_ev(EV_BUZ_UP, 3);
        push_ev(EV_BUZ_UP, 7);
        push_ev(EV_BUSY_DN, 11);
        push_ev(EV_DONE, 11);
        push_ev(EV_BUSY_UP, 12);
        push_ev(EV_BUZ_UP, 14);
        push_ev(EV_BUZ_UP, 18);
        push_ev(EV_BUSY_DN, 22);
        push_ev(EV_DONE, 22);
        do_start(2, 1, 0, 1);
        wait_rel(11);
        start = 1'b1;
        wait_rel(12);
        start = 1'b0;
        settle("drain_back_to_back", 30);

        // asynchronous reset mid-tone
        push_ev(EV_BUSY_UP, 1);
        push_ev(EV_BUZ_UP, 5);
        push_ev(EV_BUZ_UP, 13);
        push_ev(EV_BUSY_DN, 15);
        do_start(4, 3, 2, 1);
        wait_rel(15);
        #1 rst = 1'b0;
        #1;
        check("async_busy", int'(busy), 0);
        check("async_buz", int'(buz), 0);
        check("async_done", int'(done), 0);
        @(posedge clk); #2;
        rst = 1'b1;
        settle("drain_reset", 40);
        check("post_reset_state", int'(dbg_state), 0);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule

// File: doc/buzz_pattern.md
# buzz_pattern

Parametrised beeper for the buzzer output. It generates a square-wave tone at a runtime-selectable frequency and plays a sequence of N beeps, each with a programmable on time and off time in millisecond ticks. A start/stop handshake reports busy/done to the controlling logic, typically key-scan or alarm FSMs. Tone frequency, beep count and cadence are set per request, with no fixed constant.

## Interface
- TICK_DIV, 50000: clk cycles per duration tick (1 ms at 50 MHz); must be ≥ 2.
- DIV_W, 16: width of the tone half-period input.
- DUR_W, 10: width of the on/off duration inputs, in ticks.
- CNT_W, 4: width of the beep-count input.

- clk  input  1  system clock.
- rst  input  1  asynchronous reset, active-low.
- start  input  1  request pulse; sampled only in IDLE.
- stop  input  1  abort; any state returns to IDLE.
- half_period  input  DIV_W  tone half-period in clk cycles; latched at start.
- on_ticks  input  DUR_W  beep length in ticks; latched at start.
- off_ticks  input  DUR_W  gap length in ticks; latched at start.
- beeps  input  CNT_W  number of beeps; latched at start.
- busy  output  1  high while in TONE or GAP.
- done  output  1  one-cycle pulse on normal completion.
- buz  output  1  buzzer drive.

## Operation
- States: IDLE, TONE, GAP. On reset: state IDLE, and buz, busy and done are all 0. All internal counters are 0.
- IDLE:
  - If start=1, stop=0, beeps≠0 and on_ticks≠0, latch all config and enter TONE.
  - If start=1 with beeps=0 or on_ticks=0, stay in IDLE and pulse done next cycle. busy is never raised.
  - If start and stop are both 1, stop wins and nothing happens.
- TONE:
  - Tone counter runs 0..half_period−1. buz toggles when the counter reaches half_period−1, then the counter wraps.
  - buz is 0 on TONE entry, and the tone counter is cleared on every TONE entry.
  - If the latched half_period is 0, buz stays 0 (silent beep), but the timing is unchanged.
- Duration: a prescaler counts 0..TICK_DIV−1 and is cleared on every TONE/GAP entry. A tick counter counts prescaler wraps, so each phase lasts exactly ticks×TICK_DIV cycles.
- End of TONE:
  - If beeps remaining > 1 and off_ticks ≠ 0, go to GAP.
  - If beeps remaining > 1 and off_ticks = 0, re-enter TONE directly; the tone counter and buz restart.
  - If this was the last beep, go to IDLE and pulse done.
- End of GAP: decrement the remaining count and enter TONE.
- GAP: buz forced 0.
- stop=1 in TONE or GAP: IDLE next cycle with buz=0 and busy=0. No done pulse.
- start while busy is ignored. Input changes while busy have no effect, because config is latched.
- buz is registered and is forced 0 in every non-TONE state.

## Timing
- start sampled high at edge k (cycle 0) → busy=1 and state TONE from cycle 1.
- First buz rise at cycle 1+half_period. Tone period is 2×half_period cycles. 
- Busy duration = beeps×on_ticks×TICK_DIV + (beeps−1)×off_ticks×TICK_DIV cycles.
- done=1 for exactly the first IDLE cycle after the last TONE, which is the same cycle busy falls.
- stop at cycle j → busy=0 and buz=0 at cycle j+1.
- A new start is accepted in the same cycle done is high.

## Test plan
- Reset mid-TONE (rst low asynchronously) → buz, busy and done are 0 immediately. IDLE after release, with no spurious done.
- TICK_DIV=10, half_period=4, on=3, off=2, beeps=1, start pulse → busy high 30 cycles, buz period 8 cycles with first rise at cycle 5, done pulses once at cycle 31.
- Same config with beeps=3 → three 30-cycle tone bursts separated by 20-cycle silent gaps, busy 130 cycles, a single done.
- off_ticks=0, beeps=2 → 60 contiguous tone cycles, with the tone phase restarting at cycle 31 (buz low, rise at cycle 35).
- stop at cycle 15 of a burst → buz=0 and busy=0 at cycle 16, no done. A start issued while busy, or together with stop, is ignored.
- beeps=0 or on_ticks=0 → busy stays 0, done pulses one cycle after start. half_period=0 → buz stays 0 and busy timing is normal.
